// File: rtl/lynx_tape_pkg.sv
// Shared types, default timing constants and bit classification for the Lynx tape recorder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package lynx_tape_pkg;

  typedef enum logic [1:0] {IDLE, LEADER, SYNC, DATA} tape_state_t;
  typedef enum logic [1:0] {B0, B1, BAD} bit_class_t;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_MIN_PERIOD = 40;
  localparam int DEF_BIT_THRESH = 400;
  localparam int DEF_MAX_PERIOD = 1200;
  localparam int DEF_LEADER_MIN = 256;
  localparam int DEF_TIMEOUT    = 20000;

  // Classify one rising-edge interval (in us ticks) into a tape bit.
  function automatic bit_class_t classify(input logic [15:0] period,
                                          input logic [15:0] thresh,
                                          input logic [15:0] max_p);
    if (period > max_p)       return BAD;
    else if (period > thresh) return B1;
    else                      return B0;
  endfunction

endpackage

// File: rtl/lynx_tape_buf.sv
// Byte buffer: one write port, one registered read port, both on clock.
// Latency: write visible on the next clock; rd_dat valid 1 clock after rd_en.
// Backpressure: none; rd_dat holds its value when rd_en is low.
module lynx_tape_buf #(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset_osd,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_dat
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // RAM write port; contents are never reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Registered read port, cleared by reset, holds between strobes.
  always_ff @(posedge clock) begin
    if (!reset_osd)  rd_dat <= 8'h00;
    else if (rd_en)  rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/lynx_tape_rec.sv
// Records the Lynx MIC output: period-decodes leader/sync/data into bytes stored for ioctl upload.
// Latency: byte reaches RAM 2 clocks after its 8th bit edge; ioctl_din 1 clock after ioctl_rd.
// Backpressure: none; full buffer drops bytes and sets rec_overflow. LYNX_TAPE_REC_SUM_EN adds rec_sum.
module lynx_tape_rec
  import lynx_tape_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int BIT_THRESH = DEF_BIT_THRESH,
  parameter int MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int LEADER_MIN = DEF_LEADER_MIN,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset_osd,
  input  logic              ce_us,
  input  logic              mic,
  input  logic              rec_en,
  input  logic              rec_clear,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W:0]   rec_len,
  output logic              rec_busy,
  output logic              rec_overflow
`ifdef LYNX_TAPE_REC_SUM_EN
  ,
  output logic [7:0]        rec_sum
`endif
);

  localparam logic [15:0] MIN_P  = 16'(MIN_PERIOD);
  localparam logic [15:0] THR_P  = 16'(BIT_THRESH);
  localparam logic [15:0] MAX_P  = 16'(MAX_PERIOD);
  localparam logic [15:0] LMIN_P = 16'(LEADER_MIN);
  localparam logic [15:0] TO_P   = 16'(TIMEOUT);
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        sync_q;
  logic [15:0]       cnt_q, cnt_d;
  logic              edge_w, valid_edge, timeout, bit_w;
  bit_class_t        cls;
  tape_state_t       state_q;
  logic [15:0]       zero_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shreg_q, new_byte;
  logic [ADDR_W:0]   wr_ptr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_adr_q;
  logic [7:0]        wr_dat_q;
  logic              ovf_q;
`ifdef LYNX_TAPE_REC_SUM_EN
  logic [7:0]        sum_q;
  assign rec_sum = sum_q;
`endif

  // Two-flop synchroniser for MIC plus one history flop for edge detection.
  always_ff @(posedge clock) begin
    if (!reset_osd) sync_q <= 3'b000;
    else            sync_q <= {sync_q[1:0], mic};
  end

  assign edge_w     = sync_q[1] & ~sync_q[2];
  // Glitch edges leave the counter running so the real period is still measured.
  assign valid_edge = edge_w && (cnt_q >= MIN_P);
  assign timeout    = (cnt_q >= TO_P);
  assign cls        = classify(cnt_q, THR_P, MAX_P);
  assign bit_w      = (cls == B1);
  assign new_byte   = {shreg_q[6:0], bit_w};

  // Period counter: saturating us-tick count since the last valid edge.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_edge)                      cnt_d = 16'h0000;
    else if (ce_us && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Period counter register.
  always_ff @(posedge clock) begin
    if (!reset_osd) cnt_q <= 16'h0000;
    else            cnt_q <= cnt_d;
  end

  // Decoder FSM: leader detection, sync, MSB-first byte assembly and buffer writes.
  always_ff @(posedge clock) begin
    if (!reset_osd) begin
      state_q    <= IDLE;
      zero_cnt_q <= 16'h0000;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      wr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_adr_q   <= '0;
      wr_dat_q   <= 8'h00;
      ovf_q      <= 1'b0;
`ifdef LYNX_TAPE_REC_SUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      wr_en_q <= 1'b0;
      if (rec_clear) begin
        state_q  <= IDLE;
        wr_ptr_q <= '0;
        ovf_q    <= 1'b0;
      end else if (!rec_en || ioctl_upload || timeout) begin
        state_q <= IDLE;
      end else if (valid_edge) begin
        case (state_q)
          IDLE: begin
            if (cls == B0) begin
              state_q    <= LEADER;
              zero_cnt_q <= 16'd1;
            end
          end
          LEADER: begin
            if (cls == B0) begin
              zero_cnt_q <= zero_cnt_q + 16'd1;
              if (zero_cnt_q + 16'd1 >= LMIN_P) state_q <= SYNC;
            end else begin
              state_q <= IDLE;
            end
          end
          SYNC: begin
            if (cls == B1) begin
              state_q   <= DATA;
              bit_cnt_q <= 3'd0;
`ifdef LYNX_TAPE_REC_SUM_EN
              sum_q     <= 8'h00;
`endif
            end else if (cls == BAD) begin
              state_q <= IDLE;
            end
          end
          DATA: begin
            if (cls == BAD) begin
              state_q <= IDLE;
            end else begin
              shreg_q   <= new_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (wr_ptr_q == FULL) begin
                  ovf_q <= 1'b1;
                end else begin
                  wr_en_q  <= 1'b1;
                  wr_adr_q <= wr_ptr_q[ADDR_W-1:0];
                  wr_dat_q <= new_byte;
                  wr_ptr_q <= wr_ptr_q + 1'b1;
`ifdef LYNX_TAPE_REC_SUM_EN
                  sum_q    <= sum_q ^ new_byte;
`endif
                end
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rec_len      = wr_ptr_q;
  assign rec_overflow = ovf_q;
  assign rec_busy     = (state_q == SYNC) || (state_q == DATA);

  lynx_tape_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clock     (clock),
    .reset_osd (reset_osd),
    .wr_en     (wr_en_q),
    .wr_addr   (wr_adr_q),
    .wr_dat    (wr_dat_q),
    .rd_en     (ioctl_rd),
    .rd_addr   (ioctl_addr),
    .rd_dat    (ioctl_din)
  );

endmodule

// File: tb/tb_lynx_tape_rec.sv
// Bench for lynx_tape_rec: random tape blocks against a block-level model, readback via a scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_lynx_tape_rec;

  localparam int AW   = 4;
  localparam int MINP = 8;
  localparam int THR  = 24;
  localparam int MAXP = 60;
  localparam int LMIN = 16;
  localparam int TO   = 200;
  localparam int CAP  = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_osd = 1'b0;
  logic          ce_us = 1'b1;
  logic          mic = 1'b0;
  logic          rec_en = 1'b1;
  logic          rec_clear = 1'b0;
  logic          ioctl_upload = 1'b0;
  logic          ioctl_rd = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_din;
  logic [AW:0]   rec_len;
  logic          rec_busy;
  logic          rec_overflow;
`ifdef LYNX_TAPE_REC_SUM_EN
  logic [7:0]    rec_sum;
`endif

  lynx_tape_rec #(
    .ADDR_W(AW), .MIN_PERIOD(MINP), .BIT_THRESH(THR),
    .MAX_PERIOD(MAXP), .LEADER_MIN(LMIN), .TIMEOUT(TO)
  ) dut (
    .clock        (clock),
    .reset_osd    (reset_osd),
    .ce_us        (ce_us),
    .mic          (mic),
    .rec_en       (rec_en),
    .rec_clear    (rec_clear),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .rec_len      (rec_len),
    .rec_busy     (rec_busy),
    .rec_overflow (rec_overflow)
`ifdef LYNX_TAPE_REC_SUM_EN
    ,
    .rec_sum      (rec_sum)
`endif
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  bit         ce_rand = 1'b0;
  logic [7:0] exp_mem[$];
  logic [7:0] rd_exp[$];
  logic [7:0] bq[$];
  logic       exp_ovf = 1'b0;
  logic [7:0] exp_sum = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every read strobe must be answered one clock later with the queued expectation.
  always begin
    @(posedge clock);
    if (ioctl_rd === 1'b1) begin
      @(negedge clock);
      if (rd_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %0h, expected no read", ioctl_din);
      end else begin
        check("rd_data", 32'(ioctl_din), 32'(rd_exp.pop_front()));
      end
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      ce_us = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ce_us) k++;
      @(posedge clock); #1;
    end
  endtask

  function automatic int zero_p();
    return int'($urandom_range(14, 16));
  endfunction

  function automatic int one_p();
    return int'($urandom_range(36, 44));
  endfunction

  // One MIC cycle from rising edge to rising edge; a glitch adds a spurious edge 2 ticks in.
  task automatic send_period(input int p, input bit glitch);
    int h = p / 2;
    mic = 1'b1;
    if (glitch) begin
      wait_ticks(1); mic = 1'b0;
      wait_ticks(1); mic = 1'b1;
      wait_ticks(h - 2);
    end else begin
      wait_ticks(h);
    end
    mic = 1'b0;
    wait_ticks(p - h);
  endtask

  // Block-level model: a block is stored only if recording and its leader is long enough.
  task automatic model_block(input int lead, input logic [7:0] bytes[$], input bit recording);
    if (recording && lead >= LMIN) begin
      exp_sum = 8'h00;
      foreach (bytes[i]) begin
        if (exp_mem.size() < CAP) begin
          exp_mem.push_back(bytes[i]);
          exp_sum = exp_sum ^ bytes[i];
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_len"}, 32'(rec_len), 32'(exp_mem.size()));
    check({tag, "_ovf"}, 32'(rec_overflow), 32'(exp_ovf));
    check({tag, "_busy_idle"}, 32'(rec_busy), 32'd0);
`ifdef LYNX_TAPE_REC_SUM_EN
    check({tag, "_sum"}, 32'(rec_sum), 32'(exp_sum));
`endif
  endtask

  task automatic send_block(input string tag, input int lead, input logic [7:0] bytes[$],
                            input int extra, input bit glitch, input bit recording);
    bit synced = recording && (lead >= LMIN);
    for (int i = 0; i < lead; i++) send_period(zero_p(), 1'b0);
    send_period(one_p(), glitch);
    foreach (bytes[i]) begin
      for (int b = 7; b >= 0; b--) begin
        send_period(bytes[i][b] ? one_p() : zero_p(), glitch && bytes[i][b]);
        if (i == 0 && b == 7) check({tag, "_busy_data"}, 32'(rec_busy), 32'(synced));
      end
    end
    for (int i = 0; i < extra; i++) send_period($urandom_range(0, 1) != 0 ? one_p() : zero_p(), 1'b0);
    send_period(zero_p(), 1'b0);
    mic = 1'b0;
    wait_ticks(300);
    model_block(lead, bytes, recording);
    check_status(tag);
  endtask

  task automatic read_addr(input int a, input logic [7:0] exp);
    rd_exp.push_back(exp);
    ioctl_addr = AW'(a);
    ioctl_rd = 1'b1;
    @(posedge clock); #1;
    ioctl_rd = 1'b0;
  endtask

  task automatic read_all();
    foreach (exp_mem[i]) read_addr(i, exp_mem[i]);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic clear_buf();
    rec_clear = 1'b1;
    @(posedge clock); #1;
    rec_clear = 1'b0;
    exp_mem.delete();
    exp_ovf = 1'b0;
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_len", 32'(rec_len), 32'd0);
    check("rst_busy", 32'(rec_busy), 32'd0);
    check("rst_ovf", 32'(rec_overflow), 32'd0);
    check("rst_din", 32'(ioctl_din), 32'd0);
`ifdef LYNX_TAPE_REC_SUM_EN
    check("rst_sum", 32'(rec_sum), 32'd0);
`endif
    reset_osd = 1'b1;
    wait_ticks(300);

    // Nominal block: A5, 3C.
    bq.delete(); bq.push_back(8'hA5); bq.push_back(8'h3C);
    send_block("blkA", 24, bq, 0, 1'b0, 1'b1);
    read_all();

    // Upload in progress: nothing recorded, reads still served.
    ioctl_upload = 1'b1;
    bq.delete(); bq.push_back(8'h11); bq.push_back(8'h22);
    send_block("upload", 24, bq, 0, 1'b0, 1'b0);
    read_addr(1, 8'h3C);
    repeat (3) @(posedge clock);
    #1;
    ioctl_upload = 1'b0;

    // Recording disarmed.
    rec_en = 1'b0;
    bq.delete(); bq.push_back(8'h77);
    send_block("rec_off", 24, bq, 0, 1'b0, 1'b0);
    rec_en = 1'b1;

    // Leader too short: the sync '1' drops the decoder back to IDLE.
    bq.delete(); bq.push_back(8'hA5);
    send_block("short", 10, bq, 0, 1'b0, 1'b1);

    // Glitches inside every '1' cycle; blocks concatenate.
    bq.delete(); bq.push_back(8'hC3); bq.push_back(8'h5A);
    send_block("glitch", 20, bq, 3, 1'b1, 1'b1);
    read_all();

    // Random blocks with jittered us ticks.
    clear_buf();
    ce_rand = 1'b1;
    for (int n = 0; n < 3; n++) begin
      bq.delete();
      for (int i = 0, cnt = int'($urandom_range(1, 4)); i < cnt; i++) bq.push_back(8'($urandom));
      send_block("rand", int'($urandom_range(20, 30)), bq, int'($urandom_range(0, 7)), 1'b0, 1'b1);
    end
    ce_rand = 1'b0;
    read_all();

    // Overflow: 17 bytes into a 16-byte buffer.
    clear_buf();
    bq.delete();
    for (int i = 0; i < CAP + 1; i++) bq.push_back(8'($urandom));
    send_block("ovf", 20, bq, 0, 1'b0, 1'b1);
    read_all();
    clear_buf();
    @(posedge clock); #1;
    check("clr_len", 32'(rec_len), 32'd0);
    check("clr_ovf", 32'(rec_overflow), 32'd0);

    // Reset in the middle of DATA with three bytes stored.
    for (int i = 0; i < 20; i++) send_period(zero_p(), 1'b0);
    send_period(one_p(), 1'b0);
    bq.delete(); bq.push_back(8'hA5); bq.push_back(8'h11); bq.push_back(8'h22);
    foreach (bq[i]) for (int b = 7; b >= 0; b--) send_period(bq[i][b] ? one_p() : zero_p(), 1'b0);
    for (int i = 0; i < 4; i++) send_period(zero_p(), 1'b0);
    model_block(20, bq, 1'b1);
    read_addr(0, 8'hA5);
    repeat (3) @(posedge clock);
    #1;
    check("mid_len", 32'(rec_len), 32'd3);
    check("mid_busy", 32'(rec_busy), 32'd1);
    reset_osd = 1'b0;
    @(posedge clock); #1;
    reset_osd = 1'b1;
    exp_mem.delete();
    exp_ovf = 1'b0;
    exp_sum = 8'h00;
    check("rst2_len", 32'(rec_len), 32'd0);
    check("rst2_busy", 32'(rec_busy), 32'd0);
    check("rst2_din", 32'(ioctl_din), 32'd0);
    check("rst2_ovf", 32'(rec_overflow), 32'd0);
`ifdef LYNX_TAPE_REC_SUM_EN
    check("rst2_sum", 32'(rec_sum), 32'd0);
`endif

    for (int i = 0; i < 100 && rd_exp.size() != 0; i++) @(posedge clock);
    #1;
    check("rd_drain", 32'(rd_exp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
